// File: rtl/apb_mc_pkg.sv
// Shared types and helpers for the multi-completer APB requester.
//   state_t  : requester FSM states
//   slv_idx  : completer index taken from the top idx_w bits of an addr_w-bit address
//   onehot   : one-hot select vector for a completer index
// Addresses are passed zero-extended to 32 bits, so ADDR_W must not exceed 32.
package apb_mc_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  function automatic int unsigned slv_idx(input logic [31:0] addr, input int addr_w,
                                          input int idx_w);
    return (addr >> (addr_w - idx_w)) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  function automatic logic [31:0] onehot(input int unsigned idx);
    return 32'd1 << idx;
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Wait-state counter for the APB ACCESS phase.
//   clk, rst : clock, synchronous active-high reset
//   clr      : return count to zero
//   inc      : count one more wait cycle (saturates, never wraps)
//   expired  : count has reached TIMEOUT-1; constant 0 when TIMEOUT==0
module apb_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [TW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt <= '0;
    else if (inc && (cnt != {TW{1'b1}}))
      cnt <= cnt + 1'b1;
  end

  generate
    if (TIMEOUT == 0) begin : g_no_tmo
      assign expired = 1'b0;
    end else begin : g_tmo
      assign expired = (cnt == TW'(TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/apb_master_mc.sv
// APB (AMBA3) requester: one valid/ready command port fanned out to NUM_SLV
// completers selected by the top address bits. One transfer in flight at a time
// (IDLE -> SETUP -> ACCESS -> RESP), result held on a valid/ready response port.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   req_valid/ready/addr/write/wdata command port
//   rsp_valid/ready/rdata/err        response port (rdata 0 for writes and aborts)
//   psel/penable/pwrite/paddr/pwdata APB request signals (psel one-hot)
//   prdata/pready/pslverr            per-completer APB returns, slave i at slice i
module apb_master_mc
  import apb_mc_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic                      req_write,
  input  logic [DATA_W-1:0]         req_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic [NUM_SLV-1:0]        psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [ADDR_W-1:0]         paddr,
  output logic [DATA_W-1:0]         pwdata,
  input  logic [NUM_SLV*DATA_W-1:0] prdata,
  input  logic [NUM_SLV-1:0]        pready,
  input  logic [NUM_SLV-1:0]        pslverr
);

  localparam int IDX_W = $clog2(NUM_SLV);

  state_t             state;
  logic [IDX_W-1:0]   idx_req, idx;
  logic [DATA_W-1:0]  prd_arr [NUM_SLV];
  logic               sel_rdy, sel_err;
  logic               tmr_inc, tmr_clr, tmr_exp;

  // Index of the incoming command and of the transfer in flight (paddr is
  // stable from accept to completion, so no separate index register).
  assign idx_req = IDX_W'(slv_idx(32'(req_addr), ADDR_W, IDX_W));
  assign idx     = IDX_W'(slv_idx(32'(paddr), ADDR_W, IDX_W));

  genvar i;
  generate
    for (i = 0; i < NUM_SLV; i++) begin : g_prd
      assign prd_arr[i] = prdata[i*DATA_W +: DATA_W];
    end
  endgenerate

  // Only the addressed completer's handshake is observed.
  assign sel_rdy = pready[idx];
  assign sel_err = pslverr[idx];

  assign req_ready = (state == IDLE) && !rst;

  // Count only genuine wait cycles; stop at the abort point so the count
  // never wraps. Cleared when the response is handed off.
  assign tmr_inc = (state == ACCESS) && !sel_rdy && !tmr_exp;
  assign tmr_clr = (state == RESP) && rsp_ready;

  apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_tmr (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .inc     (tmr_inc),
    .expired (tmr_exp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      psel      <= '0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            paddr   <= req_addr;
            pwrite  <= req_write;
            pwdata  <= req_wdata;
            psel    <= NUM_SLV'(onehot(32'(idx_req)));
            penable <= 1'b0;
            state   <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          // pready wins over an abort landing on the same cycle.
          if (sel_rdy) begin
            psel      <= '0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= sel_err;
            rsp_rdata <= pwrite ? '0 : prd_arr[idx];
            state     <= RESP;
          end else if (tmr_exp) begin
            psel      <= '0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_mc.sv
module tb_apb_master_mc;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_ready, req_write;
  logic [7:0]   req_addr;
  logic [31:0]  req_wdata;
  logic         rsp_valid, rsp_ready, rsp_err;
  logic [31:0]  rsp_rdata;
  logic [3:0]   psel;
  logic         penable, pwrite;
  logic [7:0]   paddr;
  logic [31:0]  pwdata;
  logic [127:0] prdata;
  logic [3:0]   pready, pslverr;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  apb_master_mc #(.ADDR_W(8), .DATA_W(32), .NUM_SLV(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_prd(input int s, input logic [31:0] v);
    prdata[s*32 +: 32] = v;
  endtask

  // Present one command in IDLE and step through the accept edge (now in SETUP).
  task automatic issue(input logic [7:0] a, input logic w, input logic [31:0] d);
    req_addr  = a;
    req_write = w;
    req_wdata = d;
    req_valid = 1'b1;
    chk("issue_rdy", req_ready, 1'b1);
    tick;
    req_valid = 1'b0;
  endtask

  // Read slave2, pready low; late=1 raises pready on ACCESS cycle 16.
  task automatic run_timeout(input string tag, input bit late);
    pready  = 4'b0000;
    pslverr = 4'b0000;
    set_prd(2, 32'h5555AAAA);
    issue(8'h80, 1'b0, 32'h0);
    tick;                                  // ACCESS cycle 1
    for (int k = 1; k <= 15; k++) begin
      chk({tag, "_wait"}, {psel, penable, rsp_valid}, {4'b0100, 1'b1, 1'b0});
      tick;
    end
    chk({tag, "_c16"}, {psel, penable, rsp_valid}, {4'b0100, 1'b1, 1'b0});
    if (late) pready = 4'b0100;
    tick;                                  // RESP
    chk({tag, "_vld"}, {psel, penable, rsp_valid}, {4'b0000, 1'b0, 1'b1});
    chk({tag, "_err"}, rsp_err, late ? 1'b0 : 1'b1);
    chk({tag, "_rd"}, rsp_rdata, late ? 32'h5555AAAA : 32'h0);
    pready = 4'b0000;
    tick;                                  // IDLE
    chk({tag, "_idle"}, {req_ready, rsp_valid}, 2'b10);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b1; pready = '0; pslverr = '0; prdata = {4{32'hAAAAAAAA}};
    tick; tick;
    chk("rst_apb", {psel, penable, pwrite, paddr, pwdata}, '0);
    chk("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, '0);
    chk("rst_rdy", req_ready, 1'b0);
    rst = 1'b0;
    #1;
    chk("rst_rel_rdy", req_ready, 1'b1);

    // 1: write slave1, zero wait (slave0 ready too, must be ignored)
    pready = 4'b0011;
    issue(8'h40, 1'b1, 32'hDEADBEEF);
    chk("t1_setup", {psel, penable, req_ready}, {4'b0010, 1'b0, 1'b0});
    chk("t1_addr", {pwrite, paddr, pwdata}, {1'b1, 8'h40, 32'hDEADBEEF});
    tick;
    chk("t1_access", {psel, penable, rsp_valid}, {4'b0010, 1'b1, 1'b0});
    tick;
    chk("t1_resp", {psel, penable, rsp_valid, rsp_err}, {4'b0000, 1'b0, 1'b1, 1'b0});
    chk("t1_rdata", rsp_rdata, 32'h0);
    tick;
    chk("t1_idle", {req_ready, rsp_valid, paddr}, {1'b1, 1'b0, 8'h40});

    // 2: read slave3 with 3 wait states; other slaves ready with errors
    pready = 4'b0111; pslverr = 4'b0111; set_prd(3, 32'h12345678);
    issue(8'hC5, 1'b0, 32'h0);
    chk("t2_setup", psel, 4'b1000);
    tick; tick; tick;
    chk("t2_wait3", {psel, penable, rsp_valid}, {4'b1000, 1'b1, 1'b0});
    pready = 4'b1111; pslverr = 4'b0111;
    tick;
    chk("t2_resp", {rsp_valid, rsp_err}, 2'b10);
    chk("t2_rdata", rsp_rdata, 32'h12345678);
    tick;
    chk("t2_idle", req_ready, 1'b1);

    // 3: read slave0 with pslverr
    pready = 4'b0001; pslverr = 4'b0001; set_prd(0, 32'h0BADF00D);
    issue(8'h00, 1'b0, 32'h0);
    tick; tick;
    chk("t3_resp", {rsp_valid, rsp_err}, 2'b11);
    chk("t3_rdata", rsp_rdata, 32'h0BADF00D);
    tick;
    chk("t3_idle", {req_ready, rsp_valid}, 2'b10);

    // 4: timeout abort, then pready on the last cycle wins
    run_timeout("t4a", 1'b0);
    run_timeout("t4b", 1'b1);

    // 5: response back-pressure with a pending command
    rsp_ready = 1'b0; pready = 4'b1111; pslverr = 4'b0000;
    set_prd(1, 32'h11112222); set_prd(0, 32'h33334444);
    issue(8'h40, 1'b0, 32'h0);
    tick; tick;
    req_addr = 8'h00; req_write = 1'b0; req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("t5_hold", {req_ready, rsp_valid, rsp_err, psel}, {1'b0, 1'b1, 1'b0, 4'b0000});
      chk("t5_data", rsp_rdata, 32'h11112222);
      tick;
    end
    rsp_ready = 1'b1;
    tick;
    chk("t5_idle", {req_ready, rsp_valid}, 2'b10);
    tick;
    req_valid = 1'b0;
    chk("t5_next", {psel, paddr}, {4'b0001, 8'h00});
    tick; tick;
    chk("t5_rdata", {rsp_valid, rsp_rdata}, {1'b1, 32'h33334444});
    tick;

    // 6: reset mid-ACCESS, then fresh transfers
    pready = 4'b0000;
    issue(8'h40, 1'b1, 32'hCAFEF00D);
    tick; tick;
    rst = 1'b1;
    tick;
    chk("t6_apb", {psel, penable, pwrite, paddr, pwdata}, '0);
    chk("t6_rsp", {rsp_valid, rsp_err, rsp_rdata, req_ready}, '0);
    rst = 1'b0; pready = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("t6_norsp", {rsp_valid, psel}, '0);
    end
    issue(8'h41, 1'b1, 32'h12340000);
    chk("t6_setup", {psel, paddr, pwdata}, {4'b0010, 8'h41, 32'h12340000});
    tick; tick;
    chk("t6_resp", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 32'h0});
    tick;
    run_timeout("t6_tmo", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
